init_seq_ctrl: RTL and testbench
================================

# init_seq_ctrl

Sequencer that owns a small register bank and runs a self-checking initialize-then-verify pass. It writes a deterministic value pattern into every entry, waits one settle cycle, then reads each entry back and compares it. It reports `done` or `fail`, and it arbitrates bank access between its own engine and an external requester. It sits beside the regression-test datapath registers, replacing ad-hoc initial-block loading with a clocked, checkable load sequence.

## Interface
Parameters:
- `DEPTH`, 4: number of bank entries; ≥2, power of two.
- `WIDTH`, 32: entry width in bits.
- `INIT_BASE`, 22: value written to entry 0.
- `INIT_STEP`, 11: increment between consecutive entries.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a sequence (level-sampled).
- `inj_en`  in  1: fault injection enable, sampled in SETTLE.
- `inj_addr`  in  $clog2(DEPTH): entry to corrupt.
- `ext_req`  in  1: external access request.
- `ext_we`  in  1: external write (1) / read (0).
- `ext_addr`  in  $clog2(DEPTH): external address.
- `ext_wdata`  in  WIDTH: external write data.
- `ext_gnt`  out  1: combinational grant.
- `ext_rdata`  out  WIDTH: registered read data.
- `busy`  out  1: state is INIT, SETTLE or CHECK.
- `done`  out  1: state is DONE.
- `fail`  out  1: state is FAIL.
- `fail_idx`  out  $clog2(DEPTH): first mismatching entry.
- `cyc_cnt`  out  16: cycles spent busy in the current/last sequence.

## Operation
- States: IDLE, INIT, SETTLE, CHECK, DONE, FAIL. One-hot or binary encoding; implementer's choice.
- Reset sets the following:
  - state to IDLE;
  - all bank entries to 0;
  - `idx` to 0;
  - `ext_rdata`, `fail_idx` and `cyc_cnt` to 0.
  - As a result, `busy`, `done`, `fail` and `ext_gnt` are all 0.
- IDLE, DONE and FAIL are the rest states. `start`=1 in a rest state moves to INIT on the next edge and clears `idx` and `cyc_cnt`.
- `start` in any busy state is ignored.
- INIT writes `bank[idx] = INIT_BASE + idx*INIT_STEP` each cycle. The arithmetic is truncated to WIDTH bits (mod 2^WIDTH). `idx` increments each cycle; after writing `DEPTH-1`, the next state is SETTLE and `idx` is cleared.
- SETTLE lasts exactly 1 cycle. If `inj_en`=1, bit 0 of `bank[inj_addr]` is inverted at the SETTLE edge. The next state is CHECK.
- CHECK compares `bank[idx]` with the expected value each cycle:
  - On a mismatch, the next state is FAIL and `fail_idx` captures `idx`. The comparison stops at the first mismatch.
  - If entry `DEPTH-1` matches, the next state is DONE.
  - Otherwise `idx` increments.
- `cyc_cnt` increments on every edge where the state before the edge is busy. It saturates at 16'hFFFF and holds in rest states.
- Arbitration:
  - `ext_gnt = ext_req & rest_state & ~start`. A simultaneous `start` wins.
  - Granted write: the bank entry is updated at that edge.
  - Granted read: `ext_rdata` loads `bank[ext_addr]` at that edge.
  - Ungranted requests have no effect, and `ext_rdata` holds.
- External writes in DONE/FAIL do not change the status. A later `start` reinitializes every entry.

## Timing
- Take edge E0 as the edge where `start` is sampled in a rest state.
  - INIT writes occur at E1..E_DEPTH.
  - SETTLE occupies the cycle after E_DEPTH.
  - CHECK occupies E_{DEPTH+2}..E_{2·DEPTH+1}.
  - `done` is visible after E_{2·DEPTH+1}, i.e. 9 edges after E0 for DEPTH=4.
- At DONE, `cyc_cnt` = 2·DEPTH+1.
- A mismatch at entry k makes `fail` visible after E_{DEPTH+2+k}, with `cyc_cnt` = DEPTH+2+k.
- Read latency is 1 cycle: `ext_rdata` is valid the cycle after the grant.
- `rst` asserted in any state, including mid-INIT or mid-CHECK, applies the reset values at that edge. Any in-flight sequence is abandoned.
- `start` held high continuously: DONE/FAIL lasts one cycle, then a new sequence begins. The bench must pulse `start`.

## Test plan
- Reset, then a `start` pulse, DEPTH=4: bank = 22, 33, 44, 55. `busy` is high for 9 cycles, then `done`=1 with `cyc_cnt`=9, `fail`=0.
- `inj_en`=1, `inj_addr`=2: `fail` visible after E8 with `fail_idx`=2, `cyc_cnt`=8. An ext read of addr 2 returns 45.
- In DONE, ext write addr 1 = 0xDEAD then ext read addr 1: `ext_gnt`=1 both cycles and `ext_rdata`=0xDEAD one cycle after the read grant. A new `start` restores entry 1 to 33 and reaches `done`.
- `ext_req` during INIT/CHECK: `ext_gnt`=0 and the bank is unaffected. `ext_req` together with `start` in IDLE: `ext_gnt`=0 and the sequence starts.
- `rst` pulsed at E3 of a sequence: after that edge all outputs are 0, the bank is all 0 and the state is IDLE. A subsequent `start` completes with `done`.
- WIDTH=8, INIT_BASE=250, INIT_STEP=3: entries are 250, 253, 0, 3 (wrap) and the check passes.

Source files
------------

// File: rtl/init_seq_ctrl.sv
// Initialize-then-verify sequencer for a small register bank, with an
// external access port that is only granted while the engine is at rest.
module init_seq_ctrl #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 32,
  parameter int INIT_BASE = 22,
  parameter int INIT_STEP = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     inj_en,
  input  logic [$clog2(DEPTH)-1:0] inj_addr,
  input  logic                     ext_req,
  input  logic                     ext_we,
  input  logic [$clog2(DEPTH)-1:0] ext_addr,
  input  logic [WIDTH-1:0]         ext_wdata,
  output logic                     ext_gnt,
  output logic [WIDTH-1:0]         ext_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic [15:0]              cyc_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SETTLE, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t             state_q;
  logic [AW-1:0]      idx_q;
  logic [WIDTH-1:0]   bank_q [DEPTH];
  logic [WIDTH-1:0]   ext_rdata_q;
  logic [AW-1:0]      fail_idx_q;
  logic [15:0]        cyc_cnt_q;
  logic [15:0]        cyc_cnt_d;

  logic rest;
  logic launch;
  logic idx_last;
  logic mismatch;

  function automatic logic [WIDTH-1:0] pattern(input logic [AW-1:0] i);
    return WIDTH'(INIT_BASE) + WIDTH'(i) * WIDTH'(INIT_STEP);
  endfunction

  assign rest     = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);
  assign launch   = rest && start;
  assign idx_last = (idx_q == AW'(DEPTH - 1));
  assign mismatch = (bank_q[idx_q] != pattern(idx_q));

  // A start in the same cycle as a request wins the bank.
  assign ext_gnt  = ext_req && rest && !start;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (launch) begin
      cyc_cnt_d = '0;
    end else if (busy && (cyc_cnt_q != 16'hFFFF)) begin
      cyc_cnt_d = cyc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ext_rdata_q <= '0;
      fail_idx_q  <= '0;
      cyc_cnt_q   <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state_q <= S_INIT;
            idx_q   <= '0;
          end else if (ext_gnt && !ext_we) begin
            ext_rdata_q <= bank_q[ext_addr];
          end
        end
        S_INIT: begin
          if (idx_last) begin
            state_q <= S_SETTLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        S_SETTLE: state_q <= S_CHECK;
        S_CHECK: begin
          if (mismatch) begin
            state_q    <= S_FAIL;
            fail_idx_q <= idx_q;
          end else if (idx_last) begin
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Only one writer can be active per state, so the priority order is moot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (state_q == S_INIT) begin
      bank_q[idx_q] <= pattern(idx_q);
    end else if ((state_q == S_SETTLE) && inj_en) begin
      bank_q[inj_addr][0] <= ~bank_q[inj_addr][0];
    end else if (ext_gnt && ext_we) begin
      bank_q[ext_addr] <= ext_wdata;
    end
  end

  assign busy      = (state_q == S_INIT) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign fail      = (state_q == S_FAIL);
  assign ext_rdata = ext_rdata_q;
  assign fail_idx  = fail_idx_q;
  assign cyc_cnt   = cyc_cnt_q;

endmodule

// File: tb/tb_init_seq_ctrl.sv
// Bench for init_seq_ctrl: timeline-level model compared every cycle, plus
// literal expectations from the documented scenarios (incl. an 8-bit wrap case).
module tb_init_seq_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        inj_en = 1'b0;
  logic [1:0]  inj_addr = '0;
  logic        ext_req = 1'b0;
  logic        ext_we = 1'b0;
  logic [1:0]  ext_addr = '0;
  logic [31:0] ext_wdata = '0;
  logic        ext_gnt;
  logic [31:0] ext_rdata;
  logic        busy, done, fail;
  logic [1:0]  fail_idx;
  logic [15:0] cyc_cnt;

  logic        start8 = 1'b0;
  logic        req8 = 1'b0;
  logic [1:0]  addr8 = '0;
  logic        gnt8, busy8, done8, fail8;
  logic [7:0]  rdata8;
  logic [1:0]  fidx8;
  logic [15:0] cyc8;

  init_seq_ctrl #(.DEPTH(4), .WIDTH(32), .INIT_BASE(22), .INIT_STEP(11)) dut (
    .clk(clk), .rst(rst), .start(start), .inj_en(inj_en), .inj_addr(inj_addr),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .busy(busy), .done(done),
    .fail(fail), .fail_idx(fail_idx), .cyc_cnt(cyc_cnt)
  );

  init_seq_ctrl #(.DEPTH(4), .WIDTH(8), .INIT_BASE(250), .INIT_STEP(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .inj_en(1'b0), .inj_addr(2'd0),
    .ext_req(req8), .ext_we(1'b0), .ext_addr(addr8), .ext_wdata(8'd0),
    .ext_gnt(gnt8), .ext_rdata(rdata8), .busy(busy8), .done(done8),
    .fail(fail8), .fail_idx(fidx8), .cyc_cnt(cyc8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: sequence timeline measured in edges since start
  function automatic logic [31:0] pat(input int i);
    return 32'(22 + 11 * i);
  endfunction

  logic [31:0] m_bank [DEPTH];
  bit          m_active = 1'b0;
  bit          m_valid = 1'b0;
  int          m_t = 0;
  int          m_len = 0;
  int          m_k = -1;
  int          m_kind = 0;
  logic [15:0] m_cyc = '0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_fidx = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
      m_active = 1'b0;
      m_kind = 0;
      m_cyc = '0;
      m_rdata = '0;
      m_fidx = '0;
      m_valid = 1'b1;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t = 0;
        m_cyc = '0;
        m_len = 1000;
      end else if (ext_req) begin
        if (ext_we) m_bank[ext_addr] = ext_wdata;
        else m_rdata = m_bank[ext_addr];
      end
    end else begin
      m_t++;
      if (m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
      if (m_t <= DEPTH) m_bank[m_t-1] = pat(m_t - 1);
      if (m_t == DEPTH + 1) begin
        if (inj_en) m_bank[inj_addr][0] = ~m_bank[inj_addr][0];
        m_k = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (m_bank[i] != pat(i)) m_k = i;
        m_len = (m_k < 0) ? 2 * DEPTH + 1 : DEPTH + 2 + m_k;
      end
      if (m_t == m_len) begin
        m_active = 1'b0;
        m_kind = (m_k < 0) ? 1 : 2;
        if (m_k >= 0) m_fidx = m_k[1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("gnt", 32'(ext_gnt), 32'(ext_req && !m_active && !start));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(!m_active && m_kind == 1));
      chk("fail", 32'(fail), 32'(!m_active && m_kind == 2));
      chk("fail_idx", 32'(fail_idx), 32'(m_fidx));
      chk("cyc_cnt", 32'(cyc_cnt), 32'(m_cyc));
      chk("ext_rdata", ext_rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers (entered at #1 after a rising edge)
  task automatic wait_rest(output int nbusy);
    nbusy = 0;
    for (int c = 0; c < 60; c++) begin
      if (!busy) break;
      nbusy++;
      @(posedge clk); #1;
    end
    if (busy) chk("timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_seq(output int nbusy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_rest(nbusy);
  endtask

  task automatic ext_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = a;
    #1 chk({name, "_gnt"}, 32'(ext_gnt), 32'd1);
    @(posedge clk); #1;
    ext_req = 1'b0;
    chk(name, ext_rdata, exp);
  endtask

  int nb;
  logic [7:0] exp8 [4];

  initial begin
    exp8 = '{8'd250, 8'd253, 8'd0, 8'd3};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cyc", 32'(cyc_cnt), 32'd0);

    // Clean pass
    run_seq(nb);
    chk("pass_busy_cycles", 32'(nb), 32'd9);
    chk("pass_done", 32'(done), 32'd1);
    chk("pass_fail", 32'(fail), 32'd0);
    chk("pass_cyc", 32'(cyc_cnt), 32'd9);
    for (int i = 0; i < 4; i++) ext_rd(2'(i), 32'(22 + 11 * i), "pass_rd");

    // Injected fault at entry 2
    inj_en = 1'b1; inj_addr = 2'd2;
    run_seq(nb);
    inj_en = 1'b0;
    chk("inj_busy_cycles", 32'(nb), 32'd8);
    chk("inj_fail", 32'(fail), 32'd1);
    chk("inj_fail_idx", 32'(fail_idx), 32'd2);
    chk("inj_cyc", 32'(cyc_cnt), 32'd8);
    ext_rd(2'd2, 32'd45, "inj_rd2");

    // External write/read in DONE, then re-init restores the pattern
    run_seq(nb);
    chk("re_done", 32'(done), 32'd1);
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 2'd1; ext_wdata = 32'hDEAD;
    #1 chk("wr_gnt", 32'(ext_gnt), 32'd1);
    @(posedge clk); #1;
    ext_rd(2'd1, 32'hDEAD, "rd_dead");
    chk("done_after_ext", 32'(done), 32'd1);
    run_seq(nb);
    chk("restore_done", 32'(done), 32'd1);
    ext_rd(2'd1, 32'd33, "restore_rd1");

    // Request collides with start, then stays asserted (write) while busy
    start = 1'b1; ext_req = 1'b1; ext_we = 1'b1; ext_addr = 2'd0; ext_wdata = 32'h1234;
    #1 chk("start_wins_gnt", 32'(ext_gnt), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      chk("busy_no_gnt", 32'(ext_gnt), 32'd0);
      @(posedge clk); #1;
    end
    ext_req = 1'b0; ext_we = 1'b0;
    wait_rest(nb);
    chk("collide_done", 32'(done), 32'd1);
    ext_rd(2'd0, 32'd22, "collide_rd0");
    ext_rd(2'd3, 32'd55, "collide_rd3");

    // Reset mid-INIT at E3
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_cyc", 32'(cyc_cnt), 32'd0);
    chk("mid_rst_rdata", ext_rdata, 32'd0);
    ext_rd(2'd3, 32'd0, "mid_rst_rd3");
    run_seq(nb);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_cyc", 32'(cyc_cnt), 32'd9);

    // 8-bit instance: pattern wraps mod 256
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!busy8) break;
      @(posedge clk); #1;
    end
    chk("w8_done", 32'(done8), 32'd1);
    chk("w8_fail", 32'(fail8), 32'd0);
    chk("w8_cyc", 32'(cyc8), 32'd9);
    for (int i = 0; i < 4; i++) begin
      req8 = 1'b1; addr8 = 2'(i);
      #1 chk("w8_gnt", 32'(gnt8), 32'd1);
      @(posedge clk); #1;
      req8 = 1'b0;
      chk("w8_rd", 32'(rdata8), 32'(exp8[i]));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
